// File: rtl/addsub_share_arbiter.sv
// addsub_share_arbiter: round-robin time-sharing of one combinational add/sub unit
// among NREQ valid/ready requesters. Each accepted operation takes three cycles
// (IDLE grant -> EXEC -> RESP). The result returns as a one-cycle resp_valid pulse
// to the requester that issued the operation.
// Optional feature: define ADDSUB_ARB_SAT_EN to saturate resp_data on signed overflow.
module addsub_share_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned W    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ-1:0]   req_op,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   resp_valid,
  output logic [W-1:0]      resp_data,
  output logic              resp_carry,
  output logic              resp_overflow,
  output logic [W-1:0]      alu_a,
  output logic [W-1:0]      alu_b,
  output logic              alu_addsub,
  input  logic [W-1:0]      alu_out,
  input  logic              alu_carry,
  input  logic              alu_overflow,
  output logic              busy
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state;
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] grant;

  logic          any_c;
  logic [PW-1:0] pick_c;
  logic [PW-1:0] idx_c;
  logic [W-1:0]  sel_a_c;
  logic [W-1:0]  sel_b_c;
  logic          sel_op_c;
  logic [W-1:0]  cap_data_c;

  // Round-robin search: the first pending requester after rr_ptr, with wrap-around
  always_comb begin
    any_c  = 1'b0;
    pick_c = '0;
    idx_c  = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx_c = PW'((32'(rr_ptr) + k) % NREQ);
      if (!any_c && req_valid[idx_c]) begin
        any_c  = 1'b1;
        pick_c = idx_c;
      end
    end
  end

  // Operand mux for the chosen requester
  always_comb begin
    sel_a_c  = '0;
    sel_b_c  = '0;
    sel_op_c = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (pick_c == PW'(i)) begin
        sel_a_c  = req_a[i*W +: W];
        sel_b_c  = req_b[i*W +: W];
        sel_op_c = req_op[i];
      end
    end
  end

  // Result to capture at the end of EXEC (optionally saturated on overflow)
  always_comb begin
    cap_data_c = alu_out;
`ifdef ADDSUB_ARB_SAT_EN
    if (alu_overflow) begin
      cap_data_c = alu_a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
`endif
  end

  // Arbiter FSM with registered handshake, operand and result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      rr_ptr        <= PW'(NREQ - 1);
      grant         <= '0;
      req_ready     <= '0;
      resp_valid    <= '0;
      resp_data     <= '0;
      resp_carry    <= 1'b0;
      resp_overflow <= 1'b0;
      alu_a         <= '0;
      alu_b         <= '0;
      alu_addsub    <= 1'b0;
      busy          <= 1'b0;
    end else begin
      req_ready  <= '0;
      resp_valid <= '0;
      case (state)
        IDLE: begin
          if (any_c) begin
            alu_a      <= sel_a_c;
            alu_b      <= sel_b_c;
            alu_addsub <= sel_op_c;
            req_ready  <= NREQ'(1) << pick_c;
            rr_ptr     <= pick_c;
            grant      <= pick_c;
            busy       <= 1'b1;
            state      <= EXEC;
          end
        end
        EXEC: begin
          resp_data     <= cap_data_c;
          resp_carry    <= alu_carry;
          resp_overflow <= alu_overflow;
          state         <= RESP;
        end
        RESP: begin
          resp_valid <= NREQ'(1) << grant;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
